// File: rtl/coherence_pkg.sv
// Shared types for the L1/L2 coherence path: arbiter states, the L1 request record and op codes.
package coherence_pkg;

  localparam int L1_ADDR_W = 8;
  localparam int L1_DATA_W = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [L1_ADDR_W-1:0] addr;
    logic                 op;
    logic [L1_DATA_W-1:0] data;
    logic                 wb;
  } l1_req_t;

endpackage

// File: rtl/req_buffer.sv
// One-entry request capture register with a full flag; ready is the registered inverse of full.
module req_buffer
  import coherence_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_op,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_wb,
  input  logic              clear,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic              op,
  output logic [DATA_W-1:0] data,
  output logic              wb
);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wb_q, wb_d;

  // Capture only while empty, so a release and a refill never share a cycle.
  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    op_d   = op_q;
    data_d = data_q;
    wb_d   = wb_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (in_valid && !full_q) begin
      full_d = 1'b1;
      addr_d = in_addr;
      op_d   = in_op;
      data_d = in_data;
      wb_d   = in_wb;
    end else begin
      full_d = full_q;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      addr_q <= {ADDR_W{1'b0}};
      op_q   <= 1'b0;
      data_q <= {DATA_W{1'b0}};
      wb_q   <= 1'b0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      op_q   <= op_d;
      data_q <= data_d;
      wb_q   <= wb_d;
    end
  end

  assign in_ready = ~full_q;
  assign full     = full_q;
  assign addr     = addr_q;
  assign op       = op_q;
  assign data     = data_q;
  assign wb       = wb_q;

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares the single L2 request port between two L1 caches: write-backs first, round-robin
// within a class, one transaction outstanding, bounded wait for L2 completion.
module l2_request_arbiter
  import coherence_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_op,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_wb,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_op,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_wb,
  output logic              l2_valid,
  input  logic              l2_ready,
  output logic              l2_src,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_op,
  output logic [DATA_W-1:0] l2_data,
  output logic              l2_wb,
  input  logic              l2_done,
  output logic              done0,
  output logic              done1,
  output logic              timeout_err
);

  localparam int              CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t        state_q, state_d;
  logic              src_q, src_d, last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done0_q, done0_d, done1_q, done1_d, err_q, err_d;
  logic              full0_s, full1_s, clr0_s, clr1_s, win_s;
  logic              hs_s, fin_s, tmo_s;
  logic [ADDR_W-1:0] addr0_s, addr1_s;
  logic [DATA_W-1:0] data0_s, data1_s;
  logic              op0_s, op1_s, wb0_s, wb1_s;

  req_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf0 (
    .clk(clk), .rst_n(rst_n), .in_valid(req0_valid), .in_ready(req0_ready),
    .in_addr(req0_addr), .in_op(req0_op), .in_data(req0_data), .in_wb(req0_wb),
    .clear(clr0_s), .full(full0_s), .addr(addr0_s), .op(op0_s), .data(data0_s), .wb(wb0_s)
  );

  req_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf1 (
    .clk(clk), .rst_n(rst_n), .in_valid(req1_valid), .in_ready(req1_ready),
    .in_addr(req1_addr), .in_op(req1_op), .in_data(req1_data), .in_wb(req1_wb),
    .clear(clr1_s), .full(full1_s), .addr(addr1_s), .op(op1_s), .data(data1_s), .wb(wb1_s)
  );

  // Winner: a lone write-back beats a miss; otherwise the port not served last.
  always_comb begin
    win_s = 1'b0;
    if (full0_s && full1_s) begin
      if (wb0_s ^ wb1_s) begin
        win_s = wb1_s;
      end else begin
        win_s = ~last_q;
      end
    end else if (full1_s) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  assign hs_s  = (state_q == ISSUE) && l2_ready;
  assign fin_s = (state_q == WAIT) && l2_done;
  assign tmo_s = (state_q == WAIT) && !l2_done && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (full0_s || full1_s) state_d = ISSUE; else state_d = IDLE;
      ISSUE:   if (hs_s) state_d = WAIT; else state_d = ISSUE;
      WAIT:    if (fin_s || tmo_s) state_d = IDLE; else state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  // Arbitration pointer, wait counter, completion pulses and the sticky timeout flag.
  always_comb begin
    src_d   = src_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q | tmo_s;
    done0_d = fin_s & ~src_q;
    done1_d = fin_s & src_q;
    clr0_s  = (fin_s | tmo_s) & ~src_q;
    clr1_s  = (fin_s | tmo_s) & src_q;
    if ((state_q == IDLE) && (full0_s || full1_s)) begin
      src_d = win_s;
    end else begin
      src_d = src_q;
    end
    if (fin_s || tmo_s) begin
      last_d = src_q;
    end else begin
      last_d = last_q;
    end
    if (hs_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers; last_q starts at 1 so port 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= {CNT_W{1'b0}};
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      src_q   <= src_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err_q   <= err_d;
    end
  end

  // Outputs: L2 fields are muxed from the registered buffers by the registered source.
  always_comb begin
    l2_valid    = (state_q == ISSUE);
    l2_src      = src_q;
    l2_addr     = src_q ? addr1_s : addr0_s;
    l2_op       = src_q ? op1_s   : op0_s;
    l2_data     = src_q ? data1_s : data0_s;
    l2_wb       = src_q ? wb1_s   : wb0_s;
    done0       = done0_q;
    done1       = done1_q;
    timeout_err = err_q;
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: per-cycle vector tables plus hand-written
// back-pressure, timeout and asynchronous-reset sequences.
module tb_l2_request_arbiter;
  import coherence_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_op, req0_wb;
  logic       req1_valid, req1_ready, req1_op, req1_wb;
  logic [7:0] req0_addr, req0_data, req1_addr, req1_data;
  logic       l2_valid, l2_ready, l2_src, l2_op, l2_wb, l2_done;
  logic [7:0] l2_addr, l2_data;
  logic       done0, done1, timeout_err;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l2_request_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_op(req0_op), .req0_data(req0_data), .req0_wb(req0_wb),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_op(req1_op), .req1_data(req1_data), .req1_wb(req1_wb),
    .l2_valid(l2_valid), .l2_ready(l2_ready), .l2_src(l2_src), .l2_addr(l2_addr),
    .l2_op(l2_op), .l2_data(l2_data), .l2_wb(l2_wb), .l2_done(l2_done),
    .done0(done0), .done1(done1), .timeout_err(timeout_err)
  );

  typedef struct {
    logic    rst;
    logic    v0;
    l1_req_t r0;
    logic    v1;
    l1_req_t r1;
    logic    l2r;
    logic    l2d;
    logic    e_r0;
    logic    e_r1;
    logic    e_val;
    logic    e_src;
    l1_req_t e_req;
    logic    e_d0;
    logic    e_d1;
    logic    e_err;
  } vec_t;

  localparam l1_req_t NO = '0;
  vec_t tbl[$];

  function automatic l1_req_t rq(input logic [7:0] a, input logic op, input logic [7:0] d, input logic wb);
    l1_req_t r;
    r.addr = a;
    r.op   = op;
    r.data = d;
    r.wb   = wb;
    return r;
  endfunction

  task automatic chk1(input string name, input int idx, input logic act, input logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0b, expected %0b", name, idx, act, exp);
    end
  endtask

  task automatic chk8(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic clr_inputs();
    req0_valid = 1'b0; req0_addr = 8'h00; req0_op = 1'b0; req0_data = 8'h00; req0_wb = 1'b0;
    req1_valid = 1'b0; req1_addr = 8'h00; req1_op = 1'b0; req1_data = 8'h00; req1_wb = 1'b0;
    l2_ready = 1'b0; l2_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t t, input int idx);
    if (t.rst) do_reset();
    req0_valid = t.v0; req0_addr = t.r0.addr; req0_op = t.r0.op; req0_data = t.r0.data; req0_wb = t.r0.wb;
    req1_valid = t.v1; req1_addr = t.r1.addr; req1_op = t.r1.op; req1_data = t.r1.data; req1_wb = t.r1.wb;
    l2_ready = t.l2r;
    l2_done  = t.l2d;
    @(negedge clk);
    chk1("req0_ready", idx, req0_ready, t.e_r0);
    chk1("req1_ready", idx, req1_ready, t.e_r1);
    chk1("l2_valid", idx, l2_valid, t.e_val);
    if (t.e_val) begin
      chk1("l2_src", idx, l2_src, t.e_src);
      chk8("l2_addr", idx, l2_addr, t.e_req.addr);
      chk1("l2_op", idx, l2_op, t.e_req.op);
      chk8("l2_data", idx, l2_data, t.e_req.data);
      chk1("l2_wb", idx, l2_wb, t.e_req.wb);
    end
    chk1("done0", idx, done0, t.e_d0);
    chk1("done1", idx, done1, t.e_d1);
    chk1("timeout_err", idx, timeout_err, t.e_err);
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at a falling edge with l2_valid high, or records a failure after 10 cycles.
  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!l2_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk1(name, n, l2_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    clr_inputs();

    // Single port-0 read: l2_valid two cycles after accept, done 3 cycles after handshake.
    tbl.push_back(vec_t'{1'b1, 1'b1, rq(8'h3C, OP_READ, 8'h00, 1'b0), 1'b0, NO, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, rq(8'h3C, OP_READ, 8'h00, 1'b0), 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NO, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    // Simultaneous plain requests twice: order 0,1 then 0,1 again.
    tbl.push_back(vec_t'{1'b1, 1'b1, rq(8'h10, OP_READ, 8'h00, 1'b0), 1'b1, rq(8'h20, OP_READ, 8'h00, 1'b0), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rq(8'h10, OP_READ, 8'h00, 1'b0), 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NO, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, rq(8'h20, OP_READ, 8'h00, 1'b0), 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1, rq(8'h30, OP_READ, 8'h00, 1'b0), 1'b1, rq(8'h40, OP_READ, 8'h00, 1'b0), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NO, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rq(8'h30, OP_READ, 8'h00, 1'b0), 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NO, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, rq(8'h40, OP_READ, 8'h00, 1'b0), 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NO, 1'b0, 1'b1, 1'b0});
    // Port 1 write-back beats port 0 read arriving in the same cycle.
    tbl.push_back(vec_t'{1'b1, 1'b1, rq(8'h11, OP_READ, 8'h00, 1'b0), 1'b1, rq(8'h22, OP_WRITE, 8'hA5, 1'b1), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rq(8'h22, OP_WRITE, 8'hA5, 1'b1), 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NO, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, rq(8'h11, OP_READ, 8'h00, 1'b0), 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NO, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, NO, 1'b0, NO, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NO, 1'b1, 1'b0, 1'b0});

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Back-pressure: fields hold for 5 stalled cycles and a second request is refused.
    do_reset();
    req0_valid = 1'b1; req0_addr = 8'h55; req0_op = OP_WRITE; req0_data = 8'h66; req0_wb = 1'b0;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    wait_valid("bp_issue");
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid", i, l2_valid, 1'b1);
      chk8("bp_addr", i, l2_addr, 8'h55);
      chk8("bp_data", i, l2_data, 8'h66);
      chk1("bp_op", i, l2_op, OP_WRITE);
      chk1("bp_ready0", i, req0_ready, 1'b0);
      req0_valid = 1'b1; req0_addr = 8'h77; req0_data = 8'h00;
      @(negedge clk);
    end
    chk8("bp_addr_end", 0, l2_addr, 8'h55);
    req0_valid = 1'b0;
    l2_ready = 1'b1;
    @(negedge clk);
    chk1("bp_wait_valid", 0, l2_valid, 1'b0);
    l2_ready = 1'b0;
    l2_done = 1'b1;
    @(negedge clk);
    l2_done = 1'b0;
    chk1("bp_done0", 0, done0, 1'b1);
    chk1("bp_ready0_back", 0, req0_ready, 1'b1);

    // Timeout after 4 WAIT cycles with no completion; no done pulse; sticky error.
    req0_valid = 1'b1; req0_addr = 8'h99; req0_op = OP_READ;
    @(negedge clk);
    req0_valid = 1'b0;
    wait_valid("to_issue");
    l2_ready = 1'b1;
    @(negedge clk);
    l2_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk1("to_err_early", j, timeout_err, 1'b0);
      chk1("to_valid_low", j, l2_valid, 1'b0);
      chk1("to_done0_early", j, done0, 1'b0);
      @(negedge clk);
    end
    chk1("to_err_set", 0, timeout_err, 1'b1);
    chk1("to_ready0_freed", 0, req0_ready, 1'b1);
    chk1("to_done0_none", 0, done0, 1'b0);
    req0_valid = 1'b1; req0_addr = 8'hAB;
    @(negedge clk);
    req0_valid = 1'b0;
    chk1("to_done0_none2", 0, done0, 1'b0);
    wait_valid("to_next_issue");
    chk8("to_next_addr", 0, l2_addr, 8'hAB);
    chk1("to_err_sticky", 0, timeout_err, 1'b1);

    // Asynchronous reset while in WAIT, then a stray l2_done.
    l2_ready = 1'b1;
    @(negedge clk);
    l2_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_valid", 0, l2_valid, 1'b0);
    chk1("rst_ready0", 0, req0_ready, 1'b1);
    chk1("rst_ready1", 0, req1_ready, 1'b1);
    chk1("rst_err", 0, timeout_err, 1'b0);
    chk1("rst_done0", 0, done0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    l2_done = 1'b1;
    @(negedge clk);
    l2_done = 1'b0;
    @(negedge clk);
    chk1("rst_stray_done0", 0, done0, 1'b0);
    chk1("rst_stray_done1", 0, done1, 1'b0);
    chk1("rst_stray_valid", 0, l2_valid, 1'b0);
    chk1("rst_stray_err", 0, timeout_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_request_arbiter.md
# l2_request_arbiter

Arbiter and sequencer that shares the single L2/directory request port between the two L1 caches. Each L1 bypass request (address, operation, data, write-back flag) is captured in a one-entry per-port buffer. One winner is chosen, with write-backs ahead of misses and round-robin within a class. The winning request is issued to the L2 over a valid/ready handshake, and the arbiter holds off further issue until the L2 signals completion. It sits between `cacheL1` instances c00/c01 and `cacheL2`.

## Interface
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `TIMEOUT`, 15: maximum cycles in WAIT before abort; range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: L1 request present.
- `req0_ready` / `req1_ready` out 1: port buffer empty; transfer on valid&ready.
- `req0_addr` / `req1_addr` in ADDR_W: request address.
- `req0_op` / `req1_op` in 1: 0 read, 1 write.
- `req0_data` / `req1_data` in DATA_W: write data.
- `req0_wb` / `req1_wb` in 1: dirty write-back request.
- `l2_valid` out 1: request to L2 is valid.
- `l2_ready` in 1: L2 accepts the request.
- `l2_src` out 1: requester index of the issued request.
- `l2_addr` out ADDR_W, `l2_op` out 1, `l2_data` out DATA_W, `l2_wb` out 1: request fields to L2.
- `l2_done` in 1: one-cycle pulse; L2 has finished the outstanding transaction.
- `done0` / `done1` out 1: one-cycle completion pulse to the owning L1.
- `timeout_err` out 1: sticky flag; cleared only by reset.

## Operation
- FSM has three states: IDLE, ISSUE and WAIT.
- IDLE:
  - If at least one buffer is full, select a winner, register it in `src_q` and go to ISSUE.
  - Otherwise stay in IDLE.
- Winner selection:
  - If exactly one full buffer has `wb=1`, it wins.
  - Otherwise pick the port not equal to `last_q` (round-robin).
  - If only one buffer is full, it wins.
- ISSUE:
  - `l2_valid=1`; `l2_*` fields are driven from buffer `src_q`.
  - On `l2_valid & l2_ready`, go to WAIT and load the timeout counter with 0.
  - Fields stay stable while `l2_ready=0`.
- WAIT:
  - The counter increments each cycle.
  - On `l2_done`: clear buffer `src_q`, set `last_q<=src_q`, pulse `done[src_q]` next cycle, go to IDLE.
  - If the counter reaches `TIMEOUT` without `l2_done`: clear buffer `src_q`, set `timeout_err`, set `last_q<=src_q`, go to IDLE. No `done` pulse is issued.
- Buffer capture:
  - `reqN_ready = ~fullN` (registered state, no combinational path from inputs).
  - On `reqN_valid & reqN_ready` the buffer latches addr/op/data/wb and sets `fullN`.
  - A buffer cannot be freed and refilled in the same cycle: `ready` is low while full.
- `l2_done` outside WAIT is ignored.
- `l2_ready` outside ISSUE is ignored.
- Simultaneous events:
  - `l2_done` in the same cycle the counter hits `TIMEOUT`: done wins; no error.
  - Both ports request in the same cycle: both are captured; arbitration happens in the following IDLE cycle.
- Reset values:
  - State IDLE; `full0=full1=0`; `last_q=1`, so port 0 wins the first tie.
  - All outputs 0 except `req0_ready=req1_ready=1`.
- Reset mid-transaction discards both buffers and any outstanding transaction.

## Timing
- Accept at edge k: `full=1` after k. The FSM sees it in IDLE and enters ISSUE after edge k+1, so `l2_valid` is high in cycle k+1..k+2.
- Minimum request-to-`l2_valid` latency: 2 cycles.
- The handshake completes on the first edge with `l2_valid & l2_ready`. WAIT starts the next cycle.
- `l2_done` sampled at edge m in WAIT:
  - `doneN` high for cycle m..m+1.
  - `reqN_ready` high from m+1.
  - FSM is in IDLE from m+1 and may re-enter ISSUE from m+2.
- At most one transaction is outstanding.
- All outputs are registered, except `l2_*` fields, which are muxed from registered buffers by registered `src_q`.

## Structure
- Shared package `coherence_pkg`:
  - State enum `arb_state_t` {IDLE, ISSUE, WAIT}.
  - Request struct `l1_req_t` {addr, op, data, wb}.
  - Op constants `OP_READ=0`, `OP_WRITE=1`.
- Sub-module `req_buffer`: one-entry capture register with full flag and valid/ready. Instantiated twice.
- The arbiter FSM, round-robin pointer and timeout counter live in the top module.

## Test plan
- Single request:
  - Stimulus: port 0 read, addr 0x3C; `l2_ready=1`; `l2_done` 3 cycles after the handshake.
  - Required: `l2_valid` exactly 2 cycles after accept, with `l2_src=0`, `l2_addr=0x3C`, `l2_op=0`. `done0` is a single pulse. `req0_ready` returns to 1.
- Simultaneous plain requests:
  - Stimulus: both ports request after reset (addr 0x10 / 0x20).
  - Required: port 0 issued first, then port 1. A repeat pair is issued in the order 0 then 1 again (round-robin alternates).
- Write-back priority:
  - Stimulus: port 0 read 0x11 and port 1 write-back (wb=1, 0x22, data 0xA5) in the same cycle.
  - Required: port 1 issued first with `l2_wb=1`, `l2_data=0xA5`.
- Back-pressure:
  - Stimulus: hold `l2_ready=0` for 5 cycles.
  - Required: `l2_valid` stays 1 with stable fields. A second `req0_valid` sees `req0_ready=0`.
- Timeout:
  - Stimulus: `TIMEOUT=4`, no `l2_done`.
  - Required: `timeout_err=1` after 4 WAIT cycles, buffer freed, no `done0`. A next request still issues.
- Reset mid-WAIT:
  - Stimulus: assert `rst_n=0` asynchronously during WAIT.
  - Required: outputs go immediately to reset values (`l2_valid=0`, both readys 1, `timeout_err=0`). A later `l2_done` is ignored.
